// File: rtl/mem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// FSM state encoding, operation codes and LFSR constants.
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // x^4 + x^3 + 1: feedback is the XOR of state bits 3 and 2.
   localparam logic [3:0] LFSR_TAPS = 4'b1100;
   localparam logic [3:0] LFSR_SEED = 4'b0001;

   // Width of the latency counter: LAT-1 (max 14) plus extra (max 3).
   localparam int CNT_W = 5;

endpackage

// File: rtl/lat_lfsr.sv
// 4-bit Fibonacci LFSR used to draw 0..3 extra latency cycles per access.
// It steps only when the responder accepts a request, so the latency
// sequence depends on the request count rather than on elapsed time.
module lat_lfsr
   import mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       adv_i,
   output logic [1:0] draw_o
);

   logic [3:0] lfsr_q;
   logic [3:0] lfsr_d;

   // Shift left, feeding back the parity of the tapped bits.
   always_comb begin
      lfsr_d = lfsr_q;
      if (adv_i) begin
         lfsr_d = {lfsr_q[2:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   // State register, reseeded on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign draw_o = lfsr_q[1:0];

endmodule

// File: rtl/mem_stall_resp.sv
// Multi-cycle data-memory responder. One word access at a time; Stall is
// high while the access is in flight and Done pulses for one cycle at
// completion (with read data for reads).
//
// Request handshake: a request is Rd XOR Wr. It is taken on the rising
// edge when the FSM is IDLE or DONE (Stall low) and the request is legal;
// there is no separate ready -- the requester watches Stall/Done. Requests
// seen while BUSY are silently dropped. Illegal requests (Rd&Wr, odd
// address, address beyond the array) are never taken and set sticky err.
module mem_stall_resp
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DEPTH_W = 10,
   parameter int LAT     = 4,
   parameter int RAND_EN = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [15:0]       DataIn,
   input  logic              Rd,
   input  logic              Wr,
   output logic [15:0]       DataOut,
   output logic              Stall,
   output logic              Done,
   output logic              err
);

   localparam int DEPTH = 1 << DEPTH_W;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_BASE = CNT_W'(LAT - 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DEPTH_W-1:0]   idx_q, idx_d;
   logic [15:0]          wdata_q, wdata_d;
   logic                 op_q, op_d;
   logic                 err_q, err_d;

   logic [15:0]          mem_q [DEPTH];

   logic                 can_accept;
   logic                 any_req;
   logic                 addr_hi_bad;
   logic                 illegal;
   logic                 accept;
   logic [1:0]           lfsr_draw;
   logic [1:0]           extra;
   logic [CNT_W-1:0]     load_cnt;

   lat_lfsr u_lat_lfsr (
      .clk    (clk),
      .rst    (rst),
      .adv_i  (accept),
      .draw_o (lfsr_draw)
   );

   // Request qualification: legality and acceptance this cycle.
   always_comb begin
      can_accept  = (state_q != ST_BUSY);
      any_req     = Rd | Wr;
      addr_hi_bad = ((Addr >> (DEPTH_W + 1)) != '0);
      illegal     = any_req & ((Rd & Wr) | Addr[0] | addr_hi_bad);
      accept      = can_accept & (Rd ^ Wr) & ~illegal;
      extra       = (RAND_EN != 0) ? lfsr_draw : 2'b00;
      load_cnt    = CNT_BASE + CNT_W'(extra);
   end

   // Next-state logic: latch the request on accept, count down in BUSY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      op_d    = op_q;
      err_d   = err_q | (can_accept & illegal);
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               idx_d   = Addr[DEPTH_W:1];
               wdata_d = DataIn;
               op_d    = Wr ? OP_WR : OP_RD;
               cnt_d   = load_cnt;
               state_d = (load_cnt == '0) ? ST_DONE : ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         op_q    <= OP_RD;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         op_q    <= op_d;
         err_q   <= err_d;
      end
   end

   // Array write commits at the end of a write's DONE cycle; a reset in
   // that cycle drops it. The array itself is never cleared.
   always_ff @(posedge clk) begin
      if (!rst && state_q == ST_DONE && op_q == OP_WR) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   // Outputs are decoded from registered state only.
   always_comb begin
      Stall   = (state_q == ST_BUSY);
      Done    = (state_q == ST_DONE);
      DataOut = (state_q == ST_DONE && op_q == OP_RD) ? mem_q[idx_q] : 16'h0000;
      err     = err_q;
   end

endmodule

// File: tb/tb_mem_stall_resp.sv
// Directed bench for mem_stall_resp. Four instances cover LAT=4, LAT=2,
// LAT=1 and LAT=2 with random extra latency. Expected read data and
// latencies are queued when a request is issued and popped at Done.
module tb_mem_stall_resp;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- per-instance signals ----------------
   logic        rd_s    [4];
   logic        wr_s    [4];
   logic [15:0] addr_s  [4];
   logic [15:0] din_s   [4];
   logic [15:0] dout_s  [4];
   logic        stall_s [4];
   logic        done_s  [4];
   logic        err_s   [4];

   int          n_assert = 0;
   int          n_fail   = 0;

   logic [15:0] exp_q [$];
   int          lat_q [$];

   mem_stall_resp #(.ADDR_W(16), .DEPTH_W(10), .LAT(4), .RAND_EN(0)) u_lat4 (
      .clk(clk), .rst(rst), .Addr(addr_s[0]), .DataIn(din_s[0]),
      .Rd(rd_s[0]), .Wr(wr_s[0]), .DataOut(dout_s[0]),
      .Stall(stall_s[0]), .Done(done_s[0]), .err(err_s[0]));

   mem_stall_resp #(.ADDR_W(16), .DEPTH_W(10), .LAT(2), .RAND_EN(0)) u_lat2 (
      .clk(clk), .rst(rst), .Addr(addr_s[1]), .DataIn(din_s[1]),
      .Rd(rd_s[1]), .Wr(wr_s[1]), .DataOut(dout_s[1]),
      .Stall(stall_s[1]), .Done(done_s[1]), .err(err_s[1]));

   mem_stall_resp #(.ADDR_W(16), .DEPTH_W(10), .LAT(1), .RAND_EN(0)) u_lat1 (
      .clk(clk), .rst(rst), .Addr(addr_s[2]), .DataIn(din_s[2]),
      .Rd(rd_s[2]), .Wr(wr_s[2]), .DataOut(dout_s[2]),
      .Stall(stall_s[2]), .Done(done_s[2]), .err(err_s[2]));

   mem_stall_resp #(.ADDR_W(16), .DEPTH_W(10), .LAT(2), .RAND_EN(1)) u_rand (
      .clk(clk), .rst(rst), .Addr(addr_s[3]), .DataIn(din_s[3]),
      .Rd(rd_s[3]), .Wr(wr_s[3]), .DataOut(dout_s[3]),
      .Stall(stall_s[3]), .Done(done_s[3]), .err(err_s[3]));

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int k, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d);
      rd_s[k]   = rd;
      wr_s[k]   = wr;
      addr_s[k] = a;
      din_s[k]  = d;
   endtask

   // Present a request for one edge and record what it must produce.
   task automatic issue(input int k, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp_data, input int exp_lat);
      drive(k, rd, wr, a, d);
      exp_q.push_back(exp_data);
      lat_q.push_back(exp_lat);
      tick();
      drive(k, 1'b0, 1'b0, a, d);
   endtask

   // Wait (bounded) for Done on instance k; n0 is cycles already elapsed
   // since the accepting edge. Stall must be high on every cycle before.
   task automatic wait_done(input int k, input int n0, input string tag,
                            input bit check_data);
      int          n;
      bit          seen;
      int          e_lat;
      logic [15:0] e_data;
      n    = n0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         if (done_s[k]) begin
            seen = 1'b1;
         end else begin
            chk({tag, "_stall_in_flight"}, stall_s[k], 1'b1);
            tick();
            n++;
         end
      end
      chk({tag, "_done_seen"}, seen, 1'b1);
      e_lat  = lat_q.pop_front();
      e_data = exp_q.pop_front();
      if (seen) begin
         chk({tag, "_latency"}, n, e_lat);
         chk({tag, "_stall_at_done"}, stall_s[k], 1'b0);
         if (check_data) chk({tag, "_data"}, dout_s[k], e_data);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [3:0] m;
      int         rlat;
      int         rn;

      for (int k = 0; k < 4; k++) drive(k, 1'b0, 1'b0, 16'h0, 16'h0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset values on every instance.
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("reset_stall_%0d", k), stall_s[k], 1'b0);
         chk($sformatf("reset_done_%0d", k), done_s[k], 1'b0);
         chk($sformatf("reset_dout_%0d", k), dout_s[k], 16'h0);
         chk($sformatf("reset_err_%0d", k), err_s[k], 1'b0);
      end

      // LAT=4 write then read.
      issue(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 4);
      wait_done(0, 1, "wr_beef", 1'b1);
      tick();
      chk("wr_beef_done_pulse", done_s[0], 1'b0);
      issue(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 4);
      wait_done(0, 1, "rd_beef", 1'b1);
      tick();

      // Write issued mid-BUSY must be ignored.
      issue(0, 1'b0, 1'b1, 16'h0008, 16'h5555, 16'h0000, 4);
      wait_done(0, 1, "wr_5555", 1'b1);
      tick();
      issue(0, 1'b1, 1'b0, 16'h0008, 16'h0000, 16'h5555, 4);
      chk("busy_stall", stall_s[0], 1'b1);
      drive(0, 1'b0, 1'b1, 16'h0008, 16'hFFFF);
      tick();
      drive(0, 1'b0, 1'b0, 16'h0008, 16'h0000);
      wait_done(0, 2, "rd_during_busy", 1'b1);
      tick();
      chk("busy_single_done", done_s[0], 1'b0);
      chk("busy_back_idle", stall_s[0], 1'b0);
      issue(0, 1'b1, 1'b0, 16'h0008, 16'h0000, 16'h5555, 4);
      wait_done(0, 1, "rd_after_ignored", 1'b1);
      chk("busy_no_err", err_s[0], 1'b0);
      tick();

      // Reset in the middle of a write.
      issue(0, 1'b0, 1'b1, 16'h0030, 16'h1111, 16'h0000, 4);
      wait_done(0, 1, "wr_1111", 1'b1);
      tick();
      drive(0, 1'b0, 1'b1, 16'h0030, 16'hAAAA);
      tick();
      drive(0, 1'b0, 1'b0, 16'h0030, 16'h0000);
      chk("rst_mid_busy", stall_s[0], 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_stall", stall_s[0], 1'b0);
      chk("rst_done", done_s[0], 1'b0);
      chk("rst_dout", dout_s[0], 16'h0);
      chk("rst_err", err_s[0], 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("rst_no_done_%0d", i), done_s[0], 1'b0);
      end
      issue(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1111, 4);
      wait_done(0, 1, "rd_after_rst", 1'b1);
      tick();

      // LAT=2 back-to-back: read issued in the write's Done cycle.
      issue(1, 1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000, 2);
      wait_done(1, 1, "b2b_wr", 1'b1);
      issue(1, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 2);
      wait_done(1, 1, "b2b_rd", 1'b1);
      tick();
      chk("b2b_idle", done_s[1], 1'b0);

      // LAT=1: no BUSY cycle; read in write's Done cycle sees new data.
      issue(2, 1'b0, 1'b1, 16'h0040, 16'h9ABC, 16'h0000, 1);
      wait_done(2, 1, "lat1_wr", 1'b1);
      issue(2, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h9ABC, 1);
      wait_done(2, 1, "lat1_rd", 1'b1);
      tick();
      chk("lat1_idle_stall", stall_s[2], 1'b0);
      chk("lat1_idle_done", done_s[2], 1'b0);

      // Illegal requests on LAT=1 instance.
      issue(2, 1'b0, 1'b1, 16'h0004, 16'h7777, 16'h0000, 1);
      wait_done(2, 1, "ill_setup", 1'b1);
      tick();
      chk("ill_err_before", err_s[2], 1'b0);
      drive(2, 1'b1, 1'b1, 16'h0004, 16'hDEAD);
      tick();
      drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("ill_rdwr_err", err_s[2], 1'b1);
      chk("ill_rdwr_done", done_s[2], 1'b0);
      chk("ill_rdwr_stall", stall_s[2], 1'b0);
      drive(2, 1'b1, 1'b0, 16'h0003, 16'h0000);
      tick();
      drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("ill_odd_err", err_s[2], 1'b1);
      chk("ill_odd_done", done_s[2], 1'b0);
      chk("ill_odd_stall", stall_s[2], 1'b0);
      drive(2, 1'b0, 1'b1, 16'h0804, 16'h0BAD);
      tick();
      drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("ill_hi_err", err_s[2], 1'b1);
      chk("ill_hi_done", done_s[2], 1'b0);
      tick();
      tick();
      chk("ill_err_sticky", err_s[2], 1'b1);
      issue(2, 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h7777, 1);
      wait_done(2, 1, "ill_array_kept", 1'b1);
      chk("ill_err_final", err_s[2], 1'b1);
      tick();

      // Random extra latency: 16 reads follow the reference LFSR.
      m = 4'b0001;
      for (int i = 0; i < 16; i++) begin
         rlat = 2 + int'(m[1:0]);
         issue(3, 1'b1, 1'b0, 16'(i * 2), 16'h0000, 16'h0000, rlat);
         rn = n_fail;
         wait_done(3, 1, $sformatf("rand_%0d", i), 1'b0);
         chk($sformatf("rand_range_%0d", i), (rlat >= 2 && rlat <= 5), 1'b1);
         tick();
         m = {m[2:0], m[3] ^ m[2]};
      end
      chk("rand_no_err", err_s[3], 1'b0);
      chk("lat4_no_err", err_s[0], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
